// File: rtl/srl_test_sequencer_if.sv
// Handshake bundle between the test harness and the SRL lane sequencer.
// master = harness side, slave = sequencer side.
interface srl_test_sequencer_if #(
  parameter int NUM_LANES     = 4,
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     start;
  logic [NUM_LANES-1:0]     lane_rst;
  logic [NUM_LANES-1:0]     lane_ce;
  logic [NUM_LANES-1:0]     lane_error;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [NUM_LANES-1:0]     err_lane_mask;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output start,
    output lane_error,
    input  lane_rst,
    input  lane_ce,
    input  busy,
    input  done,
    input  pass,
    input  err_lane_mask,
    input  err_count
  );

  modport slave (
    input  start,
    input  lane_error,
    output lane_rst,
    output lane_ce,
    output busy,
    output done,
    output pass,
    output err_lane_mask,
    output err_count
  );
endinterface

// File: rtl/srl_test_sequencer.sv
// Self-test run sequencer for SRL shift-tester lanes.
// Optional: define SRL_SEQ_STAGGER_EN to stagger lane strobes.
module srl_test_sequencer #(
  parameter int NUM_LANES     = 4,
  parameter int CE_PERIOD     = 4,
  parameter int ROUNDS        = 1,
  parameter int RESET_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_CYCLES  = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  srl_test_sequencer_if.slave bus
);

  localparam int N  = ROUNDS * 512;
  localparam int SW = $clog2(N + 1);
  localparam int PW = $clog2(CE_PERIOD);
  localparam int RS = (RESET_CYCLES > SETTLE_CYCLES) ?
                      RESET_CYCLES : SETTLE_CYCLES;
  localparam int LMAX = (RS > DRAIN_CYCLES) ? RS : DRAIN_CYCLES;
  localparam int LW = $clog2(LMAX + 1);

`ifdef SRL_SEQ_STAGGER_EN
  // The last lane strobes at the last occupied period slot.
  localparam int LAST_P = NUM_LANES - 1;
  if (CE_PERIOD < NUM_LANES) begin : g_bad_stagger
    $error("CE_PERIOD must be >= NUM_LANES when staggered");
  end
`else
  localparam int LAST_P = 0;
`endif

  if (CE_PERIOD < 4) begin : g_bad_period
    $error("CE_PERIOD must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE, RESET, SETTLE, RUN, DRAIN, DONE
  } state_t;

  state_t                   state;
  logic [LW-1:0]            len_cnt;
  logic [PW-1:0]            per_cnt;
  logic [SW-1:0]            stb_cnt;
  logic [NUM_LANES-1:0]     rst_q;
  logic [NUM_LANES-1:0]     ce_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     pass_q;
  logic [NUM_LANES-1:0]     mask_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;

  logic                     sample;
  logic [PW-1:0]            per_nxt;
  logic [NUM_LANES-1:0]     ce_nxt;
  logic [NUM_LANES-1:0]     ce_first;
  logic [NUM_LANES-1:0]     mask_nxt;
  logic [ERR_CNT_WIDTH-1:0] cnt_nxt;

  // Next strobe pattern and next error accumulators.
  always_comb begin
    sample  = (state == RUN) || (state == DRAIN);
    per_nxt = (per_cnt == PW'(CE_PERIOD - 1)) ?
              '0 : per_cnt + 1'b1;
`ifdef SRL_SEQ_STAGGER_EN
    ce_first    = '0;
    ce_first[0] = 1'b1;
    for (int i = 0; i < NUM_LANES; i++)
      ce_nxt[i] = (per_nxt == PW'(i));
`else
    ce_first = '1;
    ce_nxt   = {NUM_LANES{per_nxt == '0}};
`endif
    mask_nxt = mask_q;
    cnt_nxt  = cnt_q;
    if (sample) begin
      mask_nxt = mask_q | bus.lane_error;
      if ((|bus.lane_error) && !(&cnt_q))
        cnt_nxt = cnt_q + 1'b1;
    end
  end

  // Run FSM with registered lane controls and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_cnt <= '0;
      per_cnt <= '0;
      stb_cnt <= '0;
      rst_q   <= '0;
      ce_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mask_q <= mask_nxt;
      cnt_q  <= cnt_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RESET;
            len_cnt <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
          end
        end
        RESET: begin
          if (len_cnt == LW'(RESET_CYCLES - 1)) begin
            state   <= SETTLE;
            len_cnt <= '0;
            rst_q   <= '0;
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (len_cnt == LW'(SETTLE_CYCLES - 1)) begin
            state   <= RUN;
            per_cnt <= '0;
            stb_cnt <= '0;
            ce_q    <= ce_first;
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        RUN: begin
          if (per_cnt == PW'(LAST_P))
            stb_cnt <= stb_cnt + 1'b1;
          if (per_cnt == PW'(LAST_P) &&
              stb_cnt == SW'(N - 1)) begin
            state   <= DRAIN;
            len_cnt <= '0;
            ce_q    <= '0;
          end else begin
            per_cnt <= per_nxt;
            ce_q    <= ce_nxt;
          end
        end
        DRAIN: begin
          if (len_cnt == LW'(DRAIN_CYCLES - 1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (cnt_nxt == '0);
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lane_rst      = rst_q;
  assign bus.lane_ce       = ce_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_lane_mask = mask_q;
  assign bus.err_count     = cnt_q;

endmodule

// File: tb/tb_srl_test_sequencer.sv
// Directed bench for srl_test_sequencer (2 lanes).
// Second instance with a 4-bit counter checks saturation.
module tb_srl_test_sequencer;

`ifdef SRL_SEQ_STAGGER_EN
  localparam int LOFF = 1;
`else
  localparam int LOFF = 0;
`endif
  localparam int T_DONE = 2066 + LOFF;
  localparam int RUNLEN = T_DONE + 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] lane_error = 2'b00;

  srl_test_sequencer_if #(.NUM_LANES(2), .ERR_CNT_WIDTH(16)) bus ();
  srl_test_sequencer_if #(.NUM_LANES(2), .ERR_CNT_WIDTH(4)) bus_s ();

  assign bus.start        = start;
  assign bus.lane_error   = lane_error;
  assign bus_s.start      = start;
  assign bus_s.lane_error = lane_error;

  srl_test_sequencer #(
    .NUM_LANES(2), .CE_PERIOD(4), .ROUNDS(1),
    .RESET_CYCLES(8), .SETTLE_CYCLES(4),
    .DRAIN_CYCLES(8), .ERR_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  srl_test_sequencer #(
    .NUM_LANES(2), .CE_PERIOD(4), .ROUNDS(1),
    .RESET_CYCLES(8), .SETTLE_CYCLES(4),
    .DRAIN_CYCLES(8), .ERR_CNT_WIDTH(4)
  ) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc, md;
  bit track;
  int ce_bad, rst_bad, busy_bad, wide;
  int cnt0, cnt1, first0, last0, last1, done_cyc;
  int idle_ce;
  logic [1:0] ce_prev;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [1:0] err_of(input int m,
                                        input int c);
    logic [1:0] e;
    e = 2'b00;
    case (m)
      1: begin
        if (c >= 100 && c <= 102) e = 2'b10;
        if (c == T_DONE - 1) e = 2'b01;
      end
      2: if ((c >= 1 && c <= 12) || c == T_DONE)
        e = 2'b11;
      3: if (c >= 100 && c < 200) e = 2'b01;
      5: if (c == 100) e = 2'b01;
      default: e = 2'b00;
    endcase
    return e;
  endfunction

  task automatic clear_stats();
    ce_bad = 0; rst_bad = 0; busy_bad = 0; wide = 0;
    cnt0 = 0; cnt1 = 0; first0 = -1;
    last0 = -1; last1 = -1; done_cyc = -1;
    ce_prev = 2'b00;
  endtask

  task automatic step();
    logic e0, e1;
    @(posedge clk);
    #1;
    cyc++;
    lane_error = err_of(md, cyc);
    start = (md == 4) &&
            (cyc == 5 || cyc == 300 || cyc == T_DONE - 6);
    if (track) begin
      e0 = (cyc >= 13 && cyc <= 2057 &&
            (cyc - 13) % 4 == 0);
      e1 = (cyc >= 13 + LOFF && cyc <= 2057 + LOFF &&
            (cyc - 13 - LOFF) % 4 == 0);
      if (bus.lane_ce !== {e1, e0}) ce_bad++;
      if (bus.lane_ce[0] && ce_prev[0]) wide++;
      if (bus.lane_ce[1] && ce_prev[1]) wide++;
      ce_prev = bus.lane_ce;
      if (bus.lane_ce[0]) begin
        cnt0++;
        if (first0 < 0) first0 = cyc;
        last0 = cyc;
      end
      if (bus.lane_ce[1]) begin
        cnt1++;
        last1 = cyc;
      end
      if (bus.lane_rst !==
          ((cyc >= 1 && cyc <= 8) ? 2'b11 : 2'b00))
        rst_bad++;
      if (bus.busy !== (cyc >= 1 && cyc < T_DONE))
        busy_bad++;
      if (bus.done === 1'b1 && done_cyc < 0)
        done_cyc = cyc;
    end
  endtask

  task automatic run(input int m);
    md = m;
    clear_stats();
    cyc = 0;
    track = 1'b1;
    start = 1'b1;
    lane_error = 2'b00;
    repeat (RUNLEN) step();
  endtask

  task automatic check_timing(input string p);
    chk({p, " ce_pattern"}, ce_bad, 0);
    chk({p, " ce_width"}, wide, 0);
    chk({p, " ce_cnt0"}, cnt0, 512);
    chk({p, " ce_cnt1"}, cnt1, 512);
    chk({p, " first_ce"}, first0, 13);
    chk({p, " last_ce0"}, last0, 2057);
    chk({p, " last_ce1"}, last1, 2057 + LOFF);
    chk({p, " lane_rst"}, rst_bad, 0);
    chk({p, " busy"}, busy_bad, 0);
    chk({p, " done_cyc"}, done_cyc, T_DONE);
    chk({p, " done_held"}, bus.done, 1);
  endtask

  initial begin
    md = 0; cyc = 0; track = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst lane_rst", bus.lane_rst, 0);
    chk("rst lane_ce", bus.lane_ce, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst pass", bus.pass, 0);
    chk("rst mask", bus.err_lane_mask, 0);
    chk("rst count", bus.err_count, 0);
    rst = 1'b0;
    step();
    step();

    run(0);
    check_timing("clean");
    chk("clean pass", bus.pass, 1);
    chk("clean count", bus.err_count, 0);
    chk("clean mask", bus.err_lane_mask, 0);

    run(1);
    check_timing("inject");
    chk("inject mask", bus.err_lane_mask, 3);
    chk("inject count", bus.err_count, 4);
    chk("inject pass", bus.pass, 0);

    run(2);
    check_timing("masking");
    chk("masking count", bus.err_count, 0);
    chk("masking mask", bus.err_lane_mask, 0);
    chk("masking pass", bus.pass, 1);

    run(3);
    chk("sat count16", bus.err_count, 100);
    chk("sat count4", bus_s.err_count, 15);
    chk("sat mask", bus_s.err_lane_mask, 1);
    chk("sat pass", bus_s.pass, 0);
    chk("sat done", bus_s.done, 1);

    run(4);
    check_timing("busy_start");
    chk("busy_start pass", bus.pass, 1);

    md = 5;
    clear_stats();
    cyc = 0;
    track = 1'b0;
    start = 1'b1;
    repeat (500) step();
    chk("abort pre mask", bus.err_lane_mask, 1);
    chk("abort pre busy", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort lane_rst", bus.lane_rst, 0);
    chk("abort lane_ce", bus.lane_ce, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort pass", bus.pass, 0);
    chk("abort mask", bus.err_lane_mask, 0);
    chk("abort count", bus.err_count, 0);
    idle_ce = 0;
    while (cyc < 510) begin
      step();
      if (bus.lane_ce !== 2'b00) idle_ce++;
    end
    chk("abort no_strobe", idle_ce, 0);
    run(0);
    check_timing("restart");
    chk("restart done_abs", done_cyc + 510, 2576 + LOFF);
    chk("restart pass", bus.pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_test_sequencer.md
# srl_test_sequencer

Sequences one or more SRL shift-tester lanes through a complete self-test run. On `start` it resets all lanes, lets them settle, and issues a fixed number of `ce` strobes paced at a programmable period. It then drains the error pipeline and reports a sticky per-lane error mask, a saturating error count and a pass/fail verdict. It sits between the top-level test harness (button/UART/JTAG start) and the array of SRL tester lanes, replacing free-running `ce` generation.

## Interface
- `NUM_LANES`, 4: number of tester lanes driven and monitored (1..32).
- `CE_PERIOD`, 4: cycles between successive `ce` strobes to one lane; must be >= 4 (tester needs 3 cycles per step).
- `ROUNDS`, 1: number of full 512-entry ROM passes; total strobes per lane `N = ROUNDS*512`.
- `RESET_CYCLES`, 8: length of the `lane_rst` pulse (>= 1).
- `SETTLE_CYCLES`, 4: idle cycles between reset release and the first strobe (>= 1).
- `DRAIN_CYCLES`, 8: cycles errors are still sampled after the last strobe (>= 1).
- `ERR_CNT_WIDTH`, 16: width of `err_count`.
- Reset: `rst`, synchronous, active-high. Clock: `clk`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle run request.
- `lane_rst`  out  NUM_LANES  reset to each tester lane.
- `lane_ce`  out  NUM_LANES  step strobe to each tester lane.
- `lane_error`  in  NUM_LANES  registered error flag from each lane.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete, results valid.
- `pass`  out  1  `done` and no error seen.
- `err_lane_mask`  out  NUM_LANES  sticky per-lane error flags.
- `err_count`  out  ERR_CNT_WIDTH  number of sampled cycles with any lane error, saturating.

## Operation
- FSM states: IDLE, RESET, SETTLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`: clear `err_lane_mask` and `err_count`, go to RESET. `start` is ignored in all other states.
- RESET: `lane_rst` all ones for exactly RESET_CYCLES cycles, then go to SETTLE.
- SETTLE: SETTLE_CYCLES cycles with no strobes, then go to RUN.
- RUN: a period counter counts 0..CE_PERIOD-1. A strobe is issued when it is 0. A strobe counter counts issued strobes. The cycle after the N-th strobe, go to DRAIN; that cycle issues no strobe.
- DRAIN: DRAIN_CYCLES cycles, then go to DONE.
- DONE: holds results until `start` or `rst`.
- Error sampling applies in RUN and DRAIN only. `err_lane_mask |= lane_error`. `err_count` increments by 1 for each cycle in which `lane_error` is nonzero, and stops at all ones. `lane_error` is ignored in all other states, which masks tester reset and inhibit artefacts.
- `pass = done & (err_count == 0)`.
- Counters: strobe counter `$clog2(N+1)` bits; period and state-length counters sized to their parameter.

## Timing
- Reset values: state IDLE; `lane_rst`, `lane_ce`, `busy`, `done`, `pass`, `err_lane_mask` and `err_count` all 0. Everything is registered; no combinational path from inputs to outputs.
- `rst` during any state returns to IDLE next cycle with the reset values above. `lane_rst` is not asserted by `rst` itself.
- `start` at cycle t (IDLE): `busy` and `lane_rst` are 1 from t+1. `lane_rst` is high for t+1..t+RESET_CYCLES.
- The first strobe occurs at t+RESET_CYCLES+SETTLE_CYCLES+1. Strobe k (0-based) occurs at that cycle + k*CE_PERIOD.
- DRAIN starts the cycle after the last strobe. `done` rises, and `busy` falls, DRAIN_CYCLES cycles later and on the same edge.
- `lane_ce` pulses are exactly one cycle wide.
- `lane_error` asserted on the last DRAIN cycle is counted. Error on the first DONE cycle is not counted.

## Configuration
- `SRL_SEQ_STAGGER_EN` defined: lane i strobes at period-counter value i, so lanes step on distinct cycles. This spreads supply/routing load. Requires CE_PERIOD >= NUM_LANES; the block raises an elaboration error otherwise. RUN ends the cycle after lane NUM_LANES-1 issues its N-th strobe.
- Not defined: all lanes strobe simultaneously at period-counter value 0.

## Test plan
Defaults unless stated: NUM_LANES=2, CE_PERIOD=4, ROUNDS=1, RESET_CYCLES=8, SETTLE_CYCLES=4, DRAIN_CYCLES=8.
- Clean run: `start` at cycle 0 with `lane_error` tied 0 -> `lane_rst`=2'b11 for cycles 1-8, strobes at 13, 17, ..., 2057 (512 per lane), `done`=`pass`=1 from 2066, `err_count`=0.
- Error injection: `lane_error[1]`=1 for 3 cycles during RUN and `lane_error[0]`=1 for 1 cycle during DRAIN -> `err_lane_mask`=2'b11, `err_count`=4, `pass`=0.
- Masking: `lane_error`=2'b11 throughout RESET/SETTLE and in the first DONE cycle -> `err_count`=0, `pass`=1.
- Saturation: ERR_CNT_WIDTH=4, `lane_error[0]`=1 for 100 RUN cycles -> `err_count`=15.
- Abort/restart: `rst` at cycle 500 -> all outputs 0 at 501, no further strobes. `start` at 510 -> full run, `done` at 2576.
- `start` pulsed while `busy` -> no effect on timing. With `SRL_SEQ_STAGGER_EN` defined, lane 1 strobes exactly 1 cycle after lane 0 each period.
